// File: rtl/sd_blk_server.sv
// sd_blk_server: memory-backed responder for the four-drive SD block interface.
// Ports: CLK/RESET_N; sd_* block requests, buffer side; mem_* byte memory; busy, oob.
module sd_blk_server #(
  parameter int BLK_BITS = 9,
  parameter int IMG_BITS = 20
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [127:0]        sd_lba,
  input  logic [23:0]         sd_blk_cnt,
  input  logic [3:0]          sd_rd,
  input  logic [3:0]          sd_wr,
  output logic [3:0]          sd_ack,
  output logic [BLK_BITS-1:0] sd_buff_addr,
  output logic [7:0]          sd_buff_dout,
  output logic                sd_buff_wr,
  input  logic [31:0]         sd_buff_din,
  output logic [IMG_BITS+1:0] mem_addr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [7:0]          mem_wdata,
  input  logic [7:0]          mem_rdata,
  input  logic                mem_ready,
  output logic                busy,
  output logic                oob
);

  localparam int CW = BLK_BITS + 6;
  localparam int LW = IMG_BITS - BLK_BITS;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    RD_MEM,
    RD_PUT,
    WR_ADDR,
    WR_LAT,
    WR_MEM,
    DONE
  } state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [1:0]    drv;
  logic          is_wr;
  logic          oob_q;
  logic [31:0]   lba_q;
  logic [5:0]    blk_q;
  logic [CW-1:0] cnt;

  logic [3:0]    req;
  logic          gnt_vld;
  logic [1:0]    gnt;

  // Round robin: scan from ptr upward, first requester wins.
  always_comb begin
    req     = sd_rd | sd_wr;
    gnt_vld = 1'b0;
    gnt     = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        gnt_vld = 1'b1;
        gnt     = ptr + 2'(i);
      end
    end
  end

  logic [31:0] lba_sel;
  logic [5:0]  blk_sel;
  logic [7:0]  din_sel;

  assign lba_sel = sd_lba[{gnt, 5'b00000} +: 32];
  assign blk_sel = sd_blk_cnt[5'(gnt) * 5'd6 +: 6];
  assign din_sel = sd_buff_din[{drv, 3'b000} +: 8];

  logic [CW:0]         cnt_inc;
  logic [CW:0]         cnt_end;
  logic                last;
  logic [IMG_BITS-1:0] blk_base;
  logic [IMG_BITS-1:0] off_cur;
  logic [IMG_BITS-1:0] off_nxt;
  logic                lba_oob;

  assign cnt_inc  = {1'b0, cnt} + (CW+1)'(1);
  assign cnt_end  = {({1'b0, blk_q} + 7'd1), {BLK_BITS{1'b0}}};
  assign last     = (cnt_inc == cnt_end);
  // Offsets wrap modulo the window, so long transfers stay in the drive.
  assign blk_base = {lba_q[LW-1:0], {BLK_BITS{1'b0}}};
  assign off_cur  = blk_base + IMG_BITS'(cnt);
  assign off_nxt  = blk_base + IMG_BITS'(cnt_inc);
  assign lba_oob  = |lba_q[31:LW];

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state        <= IDLE;
      ptr          <= '0;
      drv          <= '0;
      is_wr        <= 1'b0;
      oob_q        <= 1'b0;
      lba_q        <= '0;
      blk_q        <= '0;
      cnt          <= '0;
      sd_ack       <= '0;
      sd_buff_addr <= '0;
      sd_buff_dout <= '0;
      sd_buff_wr   <= 1'b0;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      oob          <= 1'b0;
    end else begin
      oob        <= 1'b0;
      sd_buff_wr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_vld) begin
            drv    <= gnt;
            is_wr  <= !sd_rd[gnt];
            lba_q  <= lba_sel;
            blk_q  <= blk_sel;
            cnt    <= '0;
            sd_ack <= 4'b0001 << gnt;
            busy   <= 1'b1;
            state  <= GRANT;
          end
        end
        GRANT: begin
          oob_q    <= lba_oob;
          oob      <= lba_oob;
          mem_addr <= {drv, off_cur};
          if (is_wr) begin
            sd_buff_addr <= cnt[BLK_BITS-1:0];
            state        <= WR_ADDR;
          end else begin
            mem_rd <= !lba_oob;
            state  <= RD_MEM;
          end
        end
        RD_MEM: begin
          if (oob_q || mem_ready) begin
            mem_rd       <= 1'b0;
            sd_buff_addr <= cnt[BLK_BITS-1:0];
            sd_buff_dout <= oob_q ? 8'h00 : mem_rdata;
            sd_buff_wr   <= 1'b1;
            state        <= RD_PUT;
          end
        end
        RD_PUT: begin
          cnt <= cnt_inc[CW-1:0];
          if (last) begin
            sd_ack <= '0;
            busy   <= 1'b0;
            state  <= DONE;
          end else begin
            mem_addr <= {drv, off_nxt};
            mem_rd   <= !oob_q;
            state    <= RD_MEM;
          end
        end
        WR_ADDR: begin
          state <= WR_LAT;
        end
        WR_LAT: begin
          mem_wdata <= din_sel;
          if (oob_q) begin
            cnt <= cnt_inc[CW-1:0];
            if (last) begin
              sd_ack <= '0;
              busy   <= 1'b0;
              state  <= DONE;
            end else begin
              sd_buff_addr <= cnt_inc[BLK_BITS-1:0];
              state        <= WR_ADDR;
            end
          end else begin
            mem_addr <= {drv, off_cur};
            mem_wr   <= 1'b1;
            state    <= WR_MEM;
          end
        end
        WR_MEM: begin
          if (mem_ready) begin
            mem_wr <= 1'b0;
            cnt    <= cnt_inc[CW-1:0];
            if (last) begin
              sd_ack <= '0;
              busy   <= 1'b0;
              state  <= DONE;
            end else begin
              sd_buff_addr <= cnt_inc[BLK_BITS-1:0];
              state        <= WR_ADDR;
            end
          end
        end
        DONE: begin
          ptr   <= drv + 2'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_blk_server.sv
// tb_sd_blk_server: directed + random bench for sd_blk_server.
// Memory, requester buffers and a transfer-level reference model live here.
module tb_sd_blk_server;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic [127:0] sd_lba;
  logic [23:0]  sd_blk_cnt;
  logic [3:0]   sd_rd;
  logic [3:0]   sd_wr;
  logic [3:0]   sd_ack;
  logic [8:0]   sd_buff_addr;
  logic [7:0]   sd_buff_dout;
  logic         sd_buff_wr;
  logic [31:0]  sd_buff_din;
  logic [21:0]  mem_addr;
  logic         mem_rd;
  logic         mem_wr;
  logic [7:0]   mem_wdata;
  logic [7:0]   mem_rdata;
  logic         mem_ready;
  logic         busy;
  logic         oob;

  always #5 CLK = ~CLK;

  sd_blk_server dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .sd_lba(sd_lba),
    .sd_blk_cnt(sd_blk_cnt),
    .sd_rd(sd_rd),
    .sd_wr(sd_wr),
    .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .mem_wr(mem_wr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .busy(busy),
    .oob(oob)
  );

  logic [7:0] mem     [0:4194303];
  logic [7:0] ref_mem [0:4194303];
  logic [7:0] bufm    [0:3][0:511];
  int mem_delay = 0;
  int wcnt = 0;

  assign mem_ready = (mem_rd | mem_wr) && (wcnt >= mem_delay);
  assign mem_rdata = mem[mem_addr];

  always @(posedge CLK) begin
    if ((mem_rd | mem_wr) && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    for (int d = 0; d < 4; d++)
      sd_buff_din[8*d +: 8] <= bufm[d][sd_buff_addr];
  end

  logic [8:0]  st_addr_q [$];
  logic [7:0]  st_dout_q [$];
  logic [21:0] rd_addr_q [$];
  logic [21:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  int n_oob = 0;
  int n_proto = 0;
  int n_run_bad = 0;
  int run = 0;
  bit pend = 0;
  logic pend_rd;
  logic [21:0] pend_addr;
  logic [7:0] pend_wd;

  always @(negedge CLK) begin
    if (!RESET_N) begin
      pend = 0;
      run = 0;
    end else begin
      if (sd_buff_wr) begin
        st_addr_q.push_back(sd_buff_addr);
        st_dout_q.push_back(sd_buff_dout);
      end
      if (oob) n_oob++;
      if (mem_rd && mem_wr) n_proto++;
      if (mem_rd || mem_wr) begin
        if (pend && (mem_addr !== pend_addr || mem_rd !== pend_rd ||
                     (mem_wr && mem_wdata !== pend_wd)))
          n_proto++;
        pend = 1;
        pend_rd = mem_rd;
        pend_addr = mem_addr;
        pend_wd = mem_wdata;
        run++;
        if (mem_ready) begin
          if (mem_rd) rd_addr_q.push_back(mem_addr);
          else begin
            mem[mem_addr] = mem_wdata;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
          end
          if (run != mem_delay + 1) n_run_bad++;
          pend = 0;
          run = 0;
        end
      end else if (pend) begin
        n_proto++;
        pend = 0;
        run = 0;
      end
    end
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output bit ok, input int budget);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (sd_ack != 4'b0000) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok, input int budget);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (sd_ack == 4'b0000) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic clear_logs();
    st_addr_q.delete();
    st_dout_q.delete();
    rd_addr_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Reference: byte i of a transfer lives at drive*1M + (lba*512 + i) mod 1M.
  task automatic model_check(input string tag, input int d, input bit wr,
                             input logic [31:0] lba, input int blk,
                             input int qoff, input int roff);
    int n;
    int bad;
    int off;
    bit oobx;
    logic [21:0] a;
    logic [7:0] e;
    n = (blk + 1) * 512;
    oobx = (lba[31:11] != 0);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      off = (int'(lba[10:0]) * 512 + i) % (1 << 20);
      a = 22'(d * (1 << 20) + off);
      if (!wr) begin
        e = oobx ? 8'h00 : ref_mem[a];
        if (qoff + i >= st_addr_q.size()) bad++;
        else if (st_addr_q[qoff+i] !== 9'(i % 512) ||
                 st_dout_q[qoff+i] !== e) bad++;
        if (!oobx) begin
          if (roff + i >= rd_addr_q.size()) bad++;
          else if (rd_addr_q[roff+i] !== a) bad++;
        end
      end else if (!oobx) begin
        e = bufm[d][i % 512];
        if (i >= wr_addr_q.size()) bad++;
        else if (wr_addr_q[i] !== a || wr_data_q[i] !== e) bad++;
        ref_mem[a] = e;
      end
    end
    chk({tag, " data_errs"}, bad, 0);
  endtask

  task automatic run_xfer(input string tag, input int d, input bit wr,
                          input logic [31:0] lba, input int blk,
                          input int dly, input logic [3:0] extra);
    int n;
    bit oobx;
    bit ok;
    int oob0;
    int pr0;
    int rb0;
    n = (blk + 1) * 512;
    oobx = (lba[31:11] != 0);
    clear_logs();
    oob0 = n_oob;
    pr0 = n_proto;
    rb0 = n_run_bad;
    mem_delay = dly;
    @(negedge CLK);
    sd_lba[32*d +: 32] = lba;
    sd_blk_cnt[6*d +: 6] = 6'(blk);
    if (wr) sd_wr[d] = 1'b1;
    else sd_rd[d] = 1'b1;
    sd_rd = sd_rd | extra;
    wait_ack(ok, 20);
    chk({tag, " ack_seen"}, ok, 1);
    chk({tag, " ack_onehot"}, sd_ack, 4'b0001 << d);
    chk({tag, " busy"}, busy, 1);
    sd_rd = '0;
    sd_wr = '0;
    wait_idle(ok, n * (dly + 4) + 64);
    chk({tag, " done"}, ok, 1);
    chk({tag, " busy_clr"}, busy, 0);
    @(negedge CLK);
    chk({tag, " strobes"}, st_addr_q.size(), wr ? 0 : n);
    chk({tag, " memrd"}, rd_addr_q.size(), (!wr && !oobx) ? n : 0);
    chk({tag, " memwr"}, wr_addr_q.size(), (wr && !oobx) ? n : 0);
    chk({tag, " oob"}, n_oob - oob0, oobx ? 1 : 0);
    chk({tag, " proto"}, n_proto - pr0, 0);
    chk({tag, " hold"}, n_run_bad - rb0, 0);
    model_check(tag, d, wr, lba, blk, 0, 0);
  endtask

  initial begin
    bit ok;
    int gap;
    int rd;
    int rw;
    int rblk;
    int rdly;
    int rmode;
    logic [31:0] rlba;

    sd_lba = '0;
    sd_blk_cnt = '0;
    sd_rd = '0;
    sd_wr = '0;
    for (int a = 0; a < 4194304; a++) begin
      mem[a] = 8'(a ^ (a >> 8) ^ (a >> 16));
      ref_mem[a] = mem[a];
    end
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < 512; i++)
        bufm[d][i] = (d == 2) ? ~8'(i) : 8'($urandom);

    repeat (3) @(negedge CLK);
    chk("reset outputs", {sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        mem_addr, mem_rd, mem_wr, mem_wdata, busy, oob}, 0);
    RESET_N = 1'b1;

    for (int a = 'h600; a < 'h800; a++) begin
      mem[a] = 8'(a);
      ref_mem[a] = 8'(a);
    end
    run_xfer("rd0_lba3", 0, 0, 32'd3, 0, 0, 4'b0000);
    run_xfer("wr2_lba1", 2, 1, 32'd1, 1, 0, 4'b0000);

    run_xfer("rd1_pre_rr", 1, 0, 32'h40, 0, 0, 4'b0000);
    clear_logs();
    mem_delay = 0;
    @(negedge CLK);
    sd_lba[63:32] = 32'h21;
    sd_blk_cnt[11:6] = 6'd0;
    sd_lba[127:96] = 32'h37;
    sd_blk_cnt[23:18] = 6'd0;
    sd_rd = 4'b1010;
    wait_ack(ok, 20);
    chk("rr first_seen", ok, 1);
    chk("rr first_drive", sd_ack, 4'b1000);
    sd_rd[3] = 1'b0;
    wait_idle(ok, 2000);
    chk("rr first_done", ok, 1);
    gap = 0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (sd_ack != 4'b0000) begin
        ok = 1;
        break;
      end
      gap++;
      @(negedge CLK);
    end
    chk("rr second_seen", ok, 1);
    chk("rr second_drive", sd_ack, 4'b0010);
    chk("rr idle_gap", gap >= 1, 1);
    sd_rd = '0;
    wait_idle(ok, 2000);
    chk("rr second_done", ok, 1);
    @(negedge CLK);
    chk("rr strobes", st_addr_q.size(), 1024);
    model_check("rr drv3", 3, 0, 32'h37, 0, 0, 0);
    model_check("rr drv1", 1, 0, 32'h21, 0, 512, 512);

    run_xfer("oob_rd", 1, 0, 32'h800, 0, 0, 4'b0000);
    run_xfer("oob_wr", 0, 1, 32'h800, 0, 0, 4'b0000);
    run_xfer("dly5_rd", 3, 0, 32'h123, 0, 5, 4'b0000);
    run_xfer("dly2_wr", 1, 1, 32'h7FF, 1, 2, 4'b0000);

    for (int k = 0; k < 6; k++) begin
      rd = $urandom_range(0, 3);
      rw = $urandom_range(0, 1);
      rblk = $urandom_range(0, 2);
      rdly = $urandom_range(0, 2);
      rmode = $urandom_range(0, 3);
      if (rmode == 0)
        rlba = (32'h800 << $urandom_range(0, 20)) | 32'($urandom_range(0, 2047));
      else if (rmode == 1)
        rlba = 32'h7FF;
      else
        rlba = 32'($urandom_range(0, 2047));
      run_xfer($sformatf("rnd%0d", k), rd, rw[0], rlba, rblk, rdly, 4'b0000);
    end

    run_xfer("readback_drv1", 1, 0, 32'h7FF, 1, 0, 4'b0000);
    run_xfer("pre_rst_drv1", 1, 0, 32'h99, 0, 0, 4'b0000);

    clear_logs();
    mem_delay = 0;
    @(negedge CLK);
    sd_lba[95:64] = 32'h10;
    sd_blk_cnt[17:12] = 6'd0;
    sd_rd[2] = 1'b1;
    wait_ack(ok, 20);
    chk("rst ack_seen", ok, 1);
    chk("rst ack_drive", sd_ack, 4'b0100);
    sd_rd = '0;
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      if (st_addr_q.size() >= 100) begin
        ok = 1;
        break;
      end
    end
    chk("rst reach_byte100", ok, 1);
    RESET_N = 1'b0;
    @(posedge CLK);
    #1;
    chk("rst outputs_zero", {sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        mem_addr, mem_rd, mem_wr, mem_wdata, busy, oob}, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    run_xfer("rst_restart", 0, 0, 32'h5, 0, 1, 4'b0100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
